seq_alu: RTL and testbench

Clocked, parametrised successor to the combinational breadboard ALU. It supports the same five operations: ADD, SUB, MUL, DIV and MOD.
- ADD/SUB complete in one cycle.
- MUL is an iterative shift-add. DIV/MOD is an iterative restoring divide, one bit per cycle.
- A valid/ready handshake sits on both sides, so the block can be placed between an operand source and a result consumer that may stall.
- Error flags match the existing ERR encoding: ERR[0] is overflow/borrow, ERR[1] is divide-by-zero.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_muldiv.sv | 88 ++++++++
 rtl/seq_alu.sv | 123 ++++++++++++
 tb/tb_seq_alu.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, ERR bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_DZ  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [WIDTH-1:0]   IN1;
  logic [WIDTH-1:0]   IN2;
  logic [OPW-1:0]     OP;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [2*WIDTH-1:0] OUT;
  logic [1:0]         ERR;

  // Operand source / result consumer side
  modport master (
    output IN_VALID, IN1, IN2, OP, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, ERR
  );

  // ALU side
  modport slave (
    input  IN_VALID, IN1, IN2, OP, OUT_READY,
    output IN_READY, OUT_VALID, OUT, ERR
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply (shift-add) and restoring divide, one bit per cycle.
module seq_alu_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               mode_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   opa;
  logic [WIDTH:0]   addsub;
  logic [WIDTH:0]   sum;

  // One iteration step; a single WIDTH+1 bit adder/subtractor serves both modes
  always_comb begin
    shifted = {acc_q, mq_q[WIDTH-1]};
    opa     = mode_q ? shifted : {1'b0, acc_q};
    addsub  = mode_q ? (opa - {1'b0, b_q}) : (opa + {1'b0, b_q});
    sum     = '0;
    acc_d   = acc_q;
    mq_d    = mq_q;
    if (mode_q) begin
      if (!addsub[WIDTH]) begin
        acc_d = addsub[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = mq_q[0] ? addsub : {1'b0, acc_q};
      acc_d = sum[WIDTH:1];
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  // Results are presented as the value after the current step so the caller
  // can register them on the same edge that completes the last iteration.
  assign done_o      = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o   = {acc_d, mq_d};
  assign quotient_o  = mq_d;
  assign remainder_o = acc_d;

  // Iteration registers and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      acc_q  <= '0;
      mq_q   <= a_i;
      b_q    <= b_i;
      mode_q <= mode_div_i;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: FSM, valid/ready handshake, ADD/SUB path and result registers.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input  logic    CLK,
  input  logic    RST,
  seq_alu_if.slave bus
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   in1_q, in2_q;
  logic [OPW-1:0]     op_q;
  logic [2*WIDTH-1:0] out_q;
  logic [1:0]         err_q;

  logic               accept;
  logic               start_iter;
  logic               in_is_divmod;
  logic               md_done;
  logic [2*WIDTH-1:0] md_product;
  logic [WIDTH-1:0]   md_quot;
  logic [WIDTH-1:0]   md_rem;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] alu_out;
  logic [1:0]         alu_err;
  logic [2*WIDTH-1:0] iter_out;

  assign bus.IN_READY  = (state_q == IDLE) && !RST;
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.OUT       = out_q;
  assign bus.ERR       = err_q;

  assign accept       = bus.IN_VALID && bus.IN_READY;
  assign in_is_divmod = (bus.OP == OPW'(OP_DIV)) || (bus.OP == OPW'(OP_MOD));
  assign start_iter   = accept && ((bus.OP == OPW'(OP_MUL)) ||
                                   (in_is_divmod && (bus.IN2 != '0)));

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (CLK),
    .rst         (RST),
    .start_i     (start_iter),
    .mode_div_i  (bus.OP != OPW'(OP_MUL)),
    .a_i         (bus.IN1),
    .b_i         (bus.IN2),
    .done_o      (md_done),
    .product_o   (md_product),
    .quotient_o  (md_quot),
    .remainder_o (md_rem)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = start_iter ? ITER : ALU;
      ALU:  state_d = DONE;
      ITER: if (md_done) state_d = DONE;
      DONE: if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results; DIV/MOD only reach ALU state with a zero divisor
  always_comb begin
    add_sum  = {1'b0, in1_q} + {1'b0, in2_q};
    sub_diff = {1'b0, in1_q} - {1'b0, in2_q};
    alu_out  = '0;
    alu_err  = '0;
    case (op_q)
      OPW'(OP_ADD): begin
        alu_out          = {{(WIDTH-1){1'b0}}, add_sum};
        alu_err[ERR_OVF] = add_sum[WIDTH];
      end
      OPW'(OP_SUB): begin
        alu_out          = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
        alu_err[ERR_OVF] = sub_diff[WIDTH];
      end
      OPW'(OP_DIV), OPW'(OP_MOD): alu_err[ERR_DZ] = 1'b1;
      default: ;
    endcase
  end

  // Iterative result selection
  always_comb begin
    iter_out = '0;
    case (op_q)
      OPW'(OP_MUL): iter_out = md_product;
      OPW'(OP_DIV): iter_out = {{WIDTH{1'b0}}, md_quot};
      default:      iter_out = {{WIDTH{1'b0}}, md_rem};
    endcase
  end

  // State, operand capture and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in1_q <= bus.IN1;
        in2_q <= bus.IN2;
        op_q  <= bus.OP;
      end
      if (state_q == ALU) begin
        out_q <= alu_out;
        err_q <= alu_err;
      end else if ((state_q == ITER) && md_done) begin
        out_q <= iter_out;
        err_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
module tb_seq_alu;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  seq_alu_if #(.WIDTH(16), .OPW(4)) bus ();

  seq_alu #(.WIDTH(16), .OPW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Issue one operation and count edges from accept to OUT_VALID (bounded)
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, output int unsigned edges);
    bus.IN1 = a;
    bus.IN2 = b;
    bus.OP  = op;
    bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    edges = 1;
    while (bus.OUT_VALID !== 1'b1 && edges < 100) begin
      @(posedge CLK); #1;
      edges++;
    end
  endtask

  task automatic consume();
    bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (bus.OUT !== 32'd0) begin fails++; $display("FAIL reset_out got %h exp 0", bus.OUT); end
    tests++; if (bus.ERR !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", bus.ERR); end
    tests++; if (bus.OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_ovalid got %b exp 0", bus.OUT_VALID); end
    tests++; if (bus.IN_READY !== 1'b0) begin fails++; $display("FAIL reset_iready_held got %b exp 0", bus.IN_READY); end
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    tests++; if (bus.IN_READY !== 1'b1) begin fails++; $display("FAIL reset_iready_rel got %b exp 1", bus.IN_READY); end
  endtask

  task automatic test_addsub();
    int unsigned e;
    run_op(16'd11, 16'd51, 4'b0000, e);
    tests++; if (bus.OUT !== 32'd62 || bus.ERR !== 2'b00) begin fails++; $display("FAIL add got %0d/%b exp 62/00", bus.OUT, bus.ERR); end
    tests++; if (e !== 2) begin fails++; $display("FAIL add_lat got %0d exp 2", e); end
    consume();
    run_op(16'd11, 16'd51, 4'b0001, e);
    tests++; if (bus.OUT !== 32'hFFFFFFD8 || bus.ERR !== 2'b01) begin fails++; $display("FAIL sub_borrow got %h/%b exp ffffffd8/01", bus.OUT, bus.ERR); end
    tests++; if (e !== 2) begin fails++; $display("FAIL sub_lat got %0d exp 2", e); end
    consume();
    run_op(16'd51, 16'd11, 4'b0001, e);
    tests++; if (bus.OUT !== 32'd40 || bus.ERR !== 2'b00) begin fails++; $display("FAIL sub_pos got %h/%b exp 28/00", bus.OUT, bus.ERR); end
    consume();
    run_op(16'd65535, 16'd65535, 4'b0000, e);
    tests++; if (bus.OUT !== 32'd131070 || bus.ERR !== 2'b01) begin fails++; $display("FAIL add_carry got %0d/%b exp 131070/01", bus.OUT, bus.ERR); end
    consume();
  endtask

  task automatic test_mul();
    int unsigned e;
    run_op(16'd11, 16'd51, 4'b0010, e);
    tests++; if (bus.OUT !== 32'd561 || bus.ERR !== 2'b00) begin fails++; $display("FAIL mul_small got %0d/%b exp 561/00", bus.OUT, bus.ERR); end
    tests++; if (e !== 17) begin fails++; $display("FAIL mul_lat got %0d exp 17", e); end
    consume();
    run_op(16'd62091, 16'd47411, 4'b0010, e);
    tests++; if (bus.OUT !== 32'd2943796401 || bus.ERR !== 2'b00) begin fails++; $display("FAIL mul_big got %0d/%b exp 2943796401/00", bus.OUT, bus.ERR); end
    consume();
    run_op(16'd65535, 16'd65535, 4'b0010, e);
    tests++; if (bus.OUT !== 32'hFFFE0001) begin fails++; $display("FAIL mul_max got %h exp fffe0001", bus.OUT); end
    consume();
  endtask

  task automatic test_divmod();
    int unsigned e;
    run_op(16'd62091, 16'd47411, 4'b0011, e);
    tests++; if (bus.OUT !== 32'd1 || bus.ERR !== 2'b00) begin fails++; $display("FAIL div got %0d/%b exp 1/00", bus.OUT, bus.ERR); end
    tests++; if (e !== 17) begin fails++; $display("FAIL div_lat got %0d exp 17", e); end
    consume();
    run_op(16'd62091, 16'd47411, 4'b0100, e);
    tests++; if (bus.OUT !== 32'd14680 || bus.ERR !== 2'b00) begin fails++; $display("FAIL mod got %0d/%b exp 14680/00", bus.OUT, bus.ERR); end
    tests++; if (e !== 17) begin fails++; $display("FAIL mod_lat got %0d exp 17", e); end
    consume();
    run_op(16'd1000, 16'd7, 4'b0011, e);
    tests++; if (bus.OUT !== 32'd142) begin fails++; $display("FAIL div2 got %0d exp 142", bus.OUT); end
    consume();
    run_op(16'd1000, 16'd7, 4'b0100, e);
    tests++; if (bus.OUT !== 32'd6) begin fails++; $display("FAIL mod2 got %0d exp 6", bus.OUT); end
    consume();
    run_op(16'd65535, 16'd65534, 4'b0100, e);
    tests++; if (bus.OUT !== 32'd1) begin fails++; $display("FAIL mod_big got %0d exp 1", bus.OUT); end
    consume();
  endtask

  task automatic test_div_zero();
    int unsigned e;
    run_op(16'd11, 16'd0, 4'b0011, e);
    tests++; if (bus.OUT !== 32'd0 || bus.ERR !== 2'b10) begin fails++; $display("FAIL div0 got %0d/%b exp 0/10", bus.OUT, bus.ERR); end
    tests++; if (e !== 2) begin fails++; $display("FAIL div0_lat got %0d exp 2", e); end
    consume();
    run_op(16'd11, 16'd0, 4'b0100, e);
    tests++; if (bus.OUT !== 32'd0 || bus.ERR !== 2'b10) begin fails++; $display("FAIL mod0 got %0d/%b exp 0/10", bus.OUT, bus.ERR); end
    tests++; if (e !== 2) begin fails++; $display("FAIL mod0_lat got %0d exp 2", e); end
    consume();
    run_op(16'd11, 16'd51, 4'b0111, e);
    tests++; if (bus.OUT !== 32'd0 || bus.ERR !== 2'b00) begin fails++; $display("FAIL invalid_op got %0d/%b exp 0/00", bus.OUT, bus.ERR); end
    tests++; if (e !== 2) begin fails++; $display("FAIL invalid_lat got %0d exp 2", e); end
    consume();
  endtask

  task automatic test_backpressure();
    int unsigned e;
    int unsigned bad = 0;
    run_op(16'd3, 16'd4, 4'b0000, e);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.IN1 = 16'd100; bus.IN2 = 16'd1; bus.OP = 4'b0001; bus.IN_VALID = 1'b1;
      end
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b0;
      if (bus.OUT !== 32'd7 || bus.ERR !== 2'b00 || bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold bad_cycles %0d exp 0 (out %0d ov %b ir %b)", bad, bus.OUT, bus.OUT_VALID, bus.IN_READY); end
    consume();
    tests++; if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin fails++; $display("FAIL bp_release ov %b ir %b exp 0/1", bus.OUT_VALID, bus.IN_READY); end
    tests++; if (bus.OUT !== 32'd7) begin fails++; $display("FAIL bp_retain got %0d exp 7", bus.OUT); end
    bad = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL bp_ignored_in spurious_valid %0d exp 0", bad); end
  endtask

  task automatic test_reset_mid_mul();
    int unsigned e;
    int unsigned bad = 0;
    bus.IN1 = 16'd62091; bus.IN2 = 16'd47411; bus.OP = 4'b0010; bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    tests++; if (bus.OUT !== 32'd0 || bus.ERR !== 2'b00 || bus.OUT_VALID !== 1'b0) begin fails++; $display("FAIL async_rst out %0d err %b ov %b exp 0/00/0", bus.OUT, bus.ERR, bus.OUT_VALID); end
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    tests++; if (bus.IN_READY !== 1'b1) begin fails++; $display("FAIL rst_iready got %b exp 1", bus.IN_READY); end
    repeat (20) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rst_discard spurious_valid %0d exp 0", bad); end
    run_op(16'd3, 16'd4, 4'b0000, e);
    tests++; if (bus.OUT !== 32'd7 || e !== 2) begin fails++; $display("FAIL post_rst_add got %0d lat %0d exp 7 lat 2", bus.OUT, e); end
    consume();
  endtask

  initial begin
    bus.IN_VALID  = 1'b0;
    bus.IN1       = '0;
    bus.IN2       = '0;
    bus.OP        = '0;
    bus.OUT_READY = 1'b0;
    test_reset();
    test_addsub();
    test_mul();
    test_divmod();
    test_div_zero();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
